// File: rtl/rv_core_pkg.sv
// Core-wide constants and the writeback request type shared by the
// writeback arbiter and its result queue.
package rv_core_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = $clog2(NREG);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO of writeback requests; pushes while full and pops
// while empty are ignored so callers may drive push/pop unconditionally.
module wb_result_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reg_writeback_arb.sv
// Owns the register file write port: merges pipeline (A) and long-latency (B)
// results, tracks pending long-latency destinations, and bypasses operands.
module reg_writeback_arb
  import rv_core_pkg::*;
#(
  parameter int BQ_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [XLEN-1:0]   A_DATA,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [XLEN-1:0]   B_DATA,
  input  logic              ISSUE_EN,
  input  logic [ADDR_W-1:0] ISSUE_RD,
  input  logic [ADDR_W-1:0] RS1_ADDR,
  input  logic [ADDR_W-1:0] RS2_ADDR,
  input  logic [XLEN-1:0]   RF_RS1_DATA,
  input  logic [XLEN-1:0]   RF_RS2_DATA,
  output logic [XLEN-1:0]   RS1_DATA,
  output logic [XLEN-1:0]   RS2_DATA,
  output logic              RS1_BUSY,
  output logic              RS2_BUSY,
  output logic              RD_BUSY,
  output logic              WB_WE,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [XLEN-1:0]   WB_DATA
);

  // Port B handshake: a result transfers on a rising edge where B_VALID and
  // B_READY are both high; the producer holds B_VALID/B_ADDR/B_DATA stable
  // until then. B_READY depends only on registered queue occupancy.

  wb_req_t         push_req;
  wb_req_t         head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_next;

  assign B_READY   = !fifo_full;
  // Results for x0 are acknowledged but never occupy a queue slot.
  assign fifo_push = B_VALID && B_READY && (B_ADDR != '0);
  assign fifo_pop  = !A_WE && !fifo_empty;
  assign push_req  = '{addr: B_ADDR, data: B_DATA};

  wb_result_fifo #(
    .DEPTH (BQ_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port A has strict priority; the queue head only drains in A-idle cycles.
  always_comb begin
    WB_WE   = 1'b0;
    WB_ADDR = '0;
    WB_DATA = '0;
    if (A_WE) begin
      WB_WE   = 1'b1;
      WB_ADDR = A_ADDR;
      WB_DATA = A_DATA;
    end else if (!fifo_empty) begin
      WB_WE   = 1'b1;
      WB_ADDR = head.addr;
      WB_DATA = head.data;
    end
  end

  // Clear on pop first so a same-edge issue to that register leaves it pending.
  always_comb begin
    sb_next = sb;
    if (fifo_pop) sb_next[head.addr] = 1'b0;
    if (ISSUE_EN) sb_next[ISSUE_RD]  = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sb <= '0;
    else        sb <= sb_next;
  end

  assign RS1_BUSY = sb[RS1_ADDR];
  assign RS2_BUSY = sb[RS2_ADDR];
  assign RD_BUSY  = sb[ISSUE_RD];

  assign RS1_DATA = (WB_WE && (WB_ADDR == RS1_ADDR) && (RS1_ADDR != '0)) ? WB_DATA : RF_RS1_DATA;
  assign RS2_DATA = (WB_WE && (WB_ADDR == RS2_ADDR) && (RS2_ADDR != '0)) ? WB_DATA : RF_RS2_DATA;

  // Issuing to a still-pending rd is illegal unless the pending result retires on this edge.
  a_issue_pending: assert property (@(posedge CLK) disable iff (!RST_N)
    !(ISSUE_EN && sb[ISSUE_RD] && !(fifo_pop && (head.addr == ISSUE_RD))));

  a_pipe_write_pending: assert property (@(posedge CLK) disable iff (!RST_N)
    !(A_WE && sb[A_ADDR]));

endmodule

// File: doc/reg_writeback_arb.md
Name: reg_writeback_arb

Overview:
- Sits directly upstream of the 32x32 register file; owns its single write port.
- Merges the single-cycle pipeline result (port A) and long-latency unit results (port B, e.g. divider or load miss) onto that write port.
- Keeps a pending-write scoreboard for long-latency destinations.
- Supplies write-through bypass on both read operands.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; ADDR_W = $clog2(NREG).
- BQ_DEPTH, 2, port-B result queue depth (power of two, >=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- A_WE  in  1  pipeline writeback valid; no backpressure.
- A_ADDR  in  ADDR_W  pipeline rd.
- A_DATA  in  XLEN  pipeline result.
- B_VALID  in  1  long-latency result valid.
- B_READY  out  1  queue not full.
- B_ADDR  in  ADDR_W  long-latency rd.
- B_DATA  in  XLEN  long-latency result.
- ISSUE_EN  in  1  long-latency op dispatched this cycle.
- ISSUE_RD  in  ADDR_W  its destination.
- RS1_ADDR, RS2_ADDR  in  ADDR_W  decode-stage source addresses.
- RF_RS1_DATA, RF_RS2_DATA  in  XLEN  register file async read data.
- RS1_DATA, RS2_DATA  out  XLEN  bypassed operands.
- RS1_BUSY, RS2_BUSY, RD_BUSY  out  1  scoreboard hits for RS1, RS2, ISSUE_RD.
- WB_WE  out  1  to register file WRITE_EN.
- WB_ADDR  out  ADDR_W  to WRITE_ADDR.
- WB_DATA  out  XLEN  to WRITE_DATA.

Behaviour:
- Reset (async assert, sync deassert externally): queue empty, scoreboard all 0. Resulting outputs: WB_WE=0, WB_ADDR=0, WB_DATA=0, B_READY=1, all BUSY=0.
- Reset mid-operation: queued B results are discarded and pending bits are lost; the core flushes alongside.
- Write port is combinational from the select:
  - A_WE=1: WB = A fields; zero added latency.
  - Else if queue not empty: WB = queue head; pop on this edge.
  - Else: WB_WE=0, WB_ADDR=0, WB_DATA=0.
- Port A always wins. Starvation of B is accepted; the pipeline guarantees idle A slots.
- Port B handshake:
  - Push on B_VALID & B_READY at the rising edge.
  - B_READY = !full, registered-count based.
  - B_VALID must hold with stable data until accepted.
- Push and pop in the same cycle are allowed, including when full: B_READY stays 0 when full, so no push occurs that cycle. Count is unchanged for push+pop.
- Minimum B latency: accept at edge N, written at edge N+1 when A is idle.
- Writes to address 0:
  - Port A with A_ADDR=0 passes through; the register file discards it.
  - B pushes with B_ADDR=0 are accepted and dropped (not queued).
- Scoreboard (NREG bits, bit 0 hardwired 0):
  - ISSUE_EN sets bit[ISSUE_RD].
  - A queue pop clears bit[head addr].
  - Same reg set and cleared on the same edge: set wins (new op pending).
- RS1_BUSY = sb[RS1_ADDR]; RS2_BUSY = sb[RS2_ADDR]; RD_BUSY = sb[ISSUE_RD]. All combinational from state.
- Issuing to an already-pending rd, or A_WE to a pending address, is a protocol violation. Decode must stall on RD_BUSY. Simulation asserts flag both.
- Bypass: RSx_DATA = WB_DATA if WB_WE & WB_ADDR==RSx_ADDR & RSx_ADDR!=0, else RF_RSx_DATA. This covers same-cycle write/read, since the register file updates on the edge.
- No combinational path from B_VALID to B_READY.

Decomposition:
- Shared package rv_core_pkg: XLEN, NREG, ADDR_W constants; wb_req_t struct {addr, data}.
- One sub-module, wb_result_fifo: parameterized synchronous FIFO of wb_req_t with full/empty, push/pop, async active-low reset.
- Scoreboard and bypass muxes stay in the top module.

Test Plan:
1. Reset, then A_WE=1, A_ADDR=5, A_DATA=0xDEADBEEF -> same cycle WB_WE=1, WB_ADDR=5, WB_DATA=0xDEADBEEF; RS1_ADDR=5 gives RS1_DATA=0xDEADBEEF regardless of RF_RS1_DATA.
2. ISSUE_EN rd=7; two cycles later B push (7, 0x1234) with A idle -> RS1_BUSY=1 while RS1_ADDR=7 until the pop edge; WB writes (7, 0x1234) one cycle after accept; busy clears after that edge.
3. A_WE held high 4 cycles while B pushes 3 results -> B_READY drops after 2 accepts; third held; on the first A-idle cycle the queue drains in FIFO order, one per cycle, and B_READY reasserts.
4. Pop of rd=9 and ISSUE_EN rd=9 on the same edge -> sb[9]=1 afterwards; RD_BUSY=1.
5. B push with B_ADDR=0, and A_ADDR=0 with RS1_ADDR=0 -> queue count unchanged; RS1_DATA=RF_RS1_DATA; RS1_BUSY=0.
6. RST_N asserted low mid-cycle with 2 queued entries and 3 pending bits -> immediately WB_WE=0, B_READY=1, all BUSY=0; no write after release.
